cache_replacement_ctrl: RTL and testbench

CACHE_REPLACEMENT_CTRL -- requirements
Module: cache_replacement_ctrl

---
 rtl/cache_replacement_ctrl_pkg.sv | 19 +
 rtl/cache_replacement_ctrl_way_hit_encoder.sv | 16 +
 rtl/cache_replacement_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cache_replacement_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_replacement_ctrl_pkg.sv
// Shared geometry and FSM encoding for the instruction-cache refill controller.
package cache_replacement_ctrl_pkg;

  // Default address split for a 32-bit byte address with 512 lines of 64-byte blocks.
  localparam int LINE_W    = 9;
  localparam int WORD_W    = 4;
  localparam int BYTE_W    = 2;
  localparam int TAG_W     = 17;
  localparam int NUM_BANKS = 2;

  // Refill sequencer states; the encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_WRITE     = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/cache_replacement_ctrl_way_hit_encoder.sv
// Two-way hit vector to bank index; bank 0 takes priority when both ways hit.
module way_hit_encoder
  import cache_replacement_ctrl_pkg::*;
(
  input  logic [NUM_BANKS-1:0] hit,
  output logic                 bank,
  output logic                 any_hit
);

  // Bank 1 is reported only when bank 0 did not hit; no hit reports bank 0.
  always_comb begin
    bank    = hit[1] & ~hit[0];
    any_hit = |hit;
  end

endmodule

// File: rtl/cache_replacement_ctrl.sv
// Two-way instruction cache miss handler: detects an IF3 miss, fetches the
// block from L2, writes it into the LRU victim bank and reports the eviction.
//
// Handshake rule for both L2 channels: a transfer happens on the rising CLK
// edge where valid and ready are both high. The address channel holds valid
// and a stable address until that edge; the data channel only asserts ready
// while waiting for data, so data offered at any other time is dropped.
module cache_replacement_ctrl
  import cache_replacement_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 512,
  parameter int MEMORY_DEPTH  = 512,
  localparam int LW           = $clog2(MEMORY_DEPTH),
  localparam int TW           = ADDRESS_WIDTH - LW - WORD_W - BYTE_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [ADDRESS_WIDTH-1:0] PC_IF2,
  input  logic [TW-1:0]            TAG_OUT_BANK_0_IF2,
  input  logic [TW-1:0]            TAG_OUT_BANK_1_IF2,
  input  logic [ADDRESS_WIDTH-1:0] PC_IF3,
  input  logic                     PC_VALID_IF3,
  input  logic [TW-1:0]            TAG_OUT_BANK_0_IF3,
  input  logic [TW-1:0]            TAG_OUT_BANK_1_IF3,
  input  logic                     HIT_BANK_0,
  input  logic                     HIT_BANK_1,
  input  logic                     ADDRESS_TO_L2_READY_INS,
  output logic                     ADDRESS_TO_L2_VALID_INS,
  output logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_READY_INS,
  input  logic                     DATA_FROM_L2_VALID_INS,
  input  logic [BLOCK_WIDTH-1:0]   DATA_FROM_L2_INS,
  output logic                     REFILL_WE_BANK_0,
  output logic                     REFILL_WE_BANK_1,
  output logic [LW-1:0]            REFILL_LINE,
  output logic [TW-1:0]            REFILL_TAG,
  output logic [BLOCK_WIDTH-1:0]   REFILL_BLOCK,
  output logic                     REFILL_BUSY,
  output logic                     VICTIM_VALID,
  output logic [TW+LW-1:0]         VICTIM_TAG_ADDRESS,
  output logic [1:0]               STATE_DBG
);

  fsm_state_t             state_q;
  fsm_state_t             state_d;

  logic [TW-1:0]          pc_tag;
  logic [LW-1:0]          pc_line;
  logic                   miss;
  logic                   addr_fire;
  logic                   data_fire;

  logic                   hit_bank;
  logic                   any_hit;
  logic [MEMORY_DEPTH-1:0] lru_q;
  logic                   victim_bank;
  logic [TW-1:0]          victim_tag_live;

  logic [TW-1:0]          cap_tag_q;
  logic [LW-1:0]          cap_line_q;
  logic                   cap_victim_q;
  logic [TW-1:0]          cap_victim_tag_q;
  logic [BLOCK_WIDTH-1:0] block_q;

  // IF2 lookahead and the word/byte offset play no part in block refill.
  logic                   unused_inputs;
  assign unused_inputs = ^{PC_IF2, TAG_OUT_BANK_0_IF2, TAG_OUT_BANK_1_IF2,
                           PC_IF3[WORD_W+BYTE_W-1:0]};

  assign pc_tag  = PC_IF3[ADDRESS_WIDTH-1 -: TW];
  assign pc_line = PC_IF3[WORD_W+BYTE_W +: LW];

  way_hit_encoder u_way_hit_encoder (
    .hit     ({HIT_BANK_1, HIT_BANK_0}),
    .bank    (hit_bank),
    .any_hit (any_hit)
  );

  // A miss only counts while idle; later misses wait for the fetch stage to replay.
  assign miss      = (state_q == S_IDLE) && PC_VALID_IF3 && !HIT_BANK_0 && !HIT_BANK_1;
  assign addr_fire = ADDRESS_TO_L2_VALID_INS && ADDRESS_TO_L2_READY_INS;
  assign data_fire = DATA_FROM_L2_VALID_INS && DATA_FROM_L2_READY_INS;

  assign victim_bank     = lru_q[pc_line];
  assign victim_tag_live = victim_bank ? TAG_OUT_BANK_1_IF3 : TAG_OUT_BANK_0_IF3;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: request, wait for the block, write it for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (miss)      state_d = S_REQ;
      S_REQ:       if (addr_fire) state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (data_fire) state_d = S_WRITE;
      S_WRITE:                    state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Output decode: channel strobes and the one-cycle write/victim pulse.
  always_comb begin
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    DATA_FROM_L2_READY_INS  = 1'b0;
    REFILL_WE_BANK_0        = 1'b0;
    REFILL_WE_BANK_1        = 1'b0;
    VICTIM_VALID            = 1'b0;
    case (state_q)
      S_REQ:       ADDRESS_TO_L2_VALID_INS = 1'b1;
      S_WAIT_DATA: DATA_FROM_L2_READY_INS  = 1'b1;
      S_WRITE: begin
        REFILL_WE_BANK_0 = ~cap_victim_q;
        REFILL_WE_BANK_1 = cap_victim_q;
        VICTIM_VALID     = 1'b1;
      end
      default: ;
    endcase
  end

  // Stall the fetch pipeline from the miss cycle until the refill retires.
  assign REFILL_BUSY = (state_q != S_IDLE) || miss;

  // Everything the refill reports comes from these captured copies, so IF3
  // can move on while the L2 request is outstanding.
  assign ADDRESS_TO_L2_INS  = {cap_tag_q, cap_line_q, {WORD_W{1'b0}}};
  assign REFILL_LINE        = cap_line_q;
  assign REFILL_TAG         = cap_tag_q;
  assign REFILL_BLOCK       = block_q;
  assign VICTIM_TAG_ADDRESS = {cap_victim_tag_q, cap_line_q};
  assign STATE_DBG          = state_q;

  // Capture miss context at the miss, and the L2 block at its handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cap_tag_q        <= '0;
      cap_line_q       <= '0;
      cap_victim_q     <= 1'b0;
      cap_victim_tag_q <= '0;
      block_q          <= '0;
    end else begin
      if (miss) begin
        cap_tag_q        <= pc_tag;
        cap_line_q       <= pc_line;
        cap_victim_q     <= victim_bank;
        cap_victim_tag_q <= victim_tag_live;
      end
      if ((state_q == S_WAIT_DATA) && data_fire) begin
        block_q <= DATA_FROM_L2_INS;
      end
    end
  end

  // LRU bit names the bank to evict next: a hit or refill points it at the other bank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lru_q <= '0;
    end else if ((state_q == S_IDLE) && PC_VALID_IF3 && any_hit) begin
      lru_q[pc_line] <= ~hit_bank;
    end else if (state_q == S_WRITE) begin
      lru_q[cap_line_q] <= ~cap_victim_q;
    end
  end

endmodule

// File: tb/tb_cache_replacement_ctrl.sv
// Directed bench for the refill controller with an L2 request scoreboard.
module tb_cache_replacement_ctrl;

  localparam int AW = 32;
  localparam int BW = 512;
  localparam int LW = 9;
  localparam int TW = 17;

  logic          CLK;
  logic          RST_N;
  logic [AW-1:0] PC_IF2;
  logic [TW-1:0] TAG_OUT_BANK_0_IF2;
  logic [TW-1:0] TAG_OUT_BANK_1_IF2;
  logic [AW-1:0] PC_IF3;
  logic          PC_VALID_IF3;
  logic [TW-1:0] TAG_OUT_BANK_0_IF3;
  logic [TW-1:0] TAG_OUT_BANK_1_IF3;
  logic          HIT_BANK_0;
  logic          HIT_BANK_1;
  logic          ADDRESS_TO_L2_READY_INS;
  logic          ADDRESS_TO_L2_VALID_INS;
  logic [AW-3:0] ADDRESS_TO_L2_INS;
  logic          DATA_FROM_L2_READY_INS;
  logic          DATA_FROM_L2_VALID_INS;
  logic [BW-1:0] DATA_FROM_L2_INS;
  logic          REFILL_WE_BANK_0;
  logic          REFILL_WE_BANK_1;
  logic [LW-1:0] REFILL_LINE;
  logic [TW-1:0] REFILL_TAG;
  logic [BW-1:0] REFILL_BLOCK;
  logic          REFILL_BUSY;
  logic          VICTIM_VALID;
  logic [TW+LW-1:0] VICTIM_TAG_ADDRESS;
  logic [1:0]    STATE_DBG;

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  int req_snap;
  logic [AW-3:0] exp_q[$];

  logic [BW-1:0] blk_a;
  logic [BW-1:0] blk_b;
  logic [BW-1:0] blk_c;
  logic [BW-1:0] blk_junk;

  cache_replacement_ctrl dut (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .PC_IF2                  (PC_IF2),
    .TAG_OUT_BANK_0_IF2      (TAG_OUT_BANK_0_IF2),
    .TAG_OUT_BANK_1_IF2      (TAG_OUT_BANK_1_IF2),
    .PC_IF3                  (PC_IF3),
    .PC_VALID_IF3            (PC_VALID_IF3),
    .TAG_OUT_BANK_0_IF3      (TAG_OUT_BANK_0_IF3),
    .TAG_OUT_BANK_1_IF3      (TAG_OUT_BANK_1_IF3),
    .HIT_BANK_0              (HIT_BANK_0),
    .HIT_BANK_1              (HIT_BANK_1),
    .ADDRESS_TO_L2_READY_INS (ADDRESS_TO_L2_READY_INS),
    .ADDRESS_TO_L2_VALID_INS (ADDRESS_TO_L2_VALID_INS),
    .ADDRESS_TO_L2_INS       (ADDRESS_TO_L2_INS),
    .DATA_FROM_L2_READY_INS  (DATA_FROM_L2_READY_INS),
    .DATA_FROM_L2_VALID_INS  (DATA_FROM_L2_VALID_INS),
    .DATA_FROM_L2_INS        (DATA_FROM_L2_INS),
    .REFILL_WE_BANK_0        (REFILL_WE_BANK_0),
    .REFILL_WE_BANK_1        (REFILL_WE_BANK_1),
    .REFILL_LINE             (REFILL_LINE),
    .REFILL_TAG              (REFILL_TAG),
    .REFILL_BLOCK            (REFILL_BLOCK),
    .REFILL_BUSY             (REFILL_BUSY),
    .VICTIM_VALID            (VICTIM_VALID),
    .VICTIM_TAG_ADDRESS      (VICTIM_TAG_ADDRESS),
    .STATE_DBG               (STATE_DBG)
  );

  // Clock: 10 ns period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Present a single-cycle miss and record the L2 word address it must produce.
  task automatic drive_miss(input logic [AW-1:0] pc);
    PC_IF3       = pc;
    PC_VALID_IF3 = 1'b1;
    HIT_BANK_0   = 1'b0;
    HIT_BANK_1   = 1'b0;
    exp_q.push_back(pc[AW-1:2] & ~30'hF);
    tick();
    PC_VALID_IF3 = 1'b0;
  endtask

  // Scoreboard: every address handshake must match the oldest expected request.
  always @(negedge CLK) begin
    if (RST_N && ADDRESS_TO_L2_VALID_INS && ADDRESS_TO_L2_READY_INS) begin
      req_count++;
      check("l2_req_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("l2_req_addr", 32'(ADDRESS_TO_L2_INS), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    blk_a    = {16{32'hA5A5_0001}};
    blk_b    = {16{32'h1234_5678}};
    blk_c    = {16{32'hC0DE_F00D}};
    blk_junk = {16{32'hDEAD_BEEF}};

    RST_N = 1'b0;
    PC_IF2 = '0; TAG_OUT_BANK_0_IF2 = '0; TAG_OUT_BANK_1_IF2 = '0;
    PC_IF3 = '0; PC_VALID_IF3 = 1'b0;
    TAG_OUT_BANK_0_IF3 = '0; TAG_OUT_BANK_1_IF3 = '0;
    HIT_BANK_0 = 1'b0; HIT_BANK_1 = 1'b0;
    ADDRESS_TO_L2_READY_INS = 1'b0;
    DATA_FROM_L2_VALID_INS = 1'b0; DATA_FROM_L2_INS = '0;

    // Reset state.
    #12;
    check("rst_state", 32'(STATE_DBG), 32'd0);
    check("rst_addr_valid", 32'(ADDRESS_TO_L2_VALID_INS), 32'd0);
    check("rst_data_ready", 32'(DATA_FROM_L2_READY_INS), 32'd0);
    check("rst_we", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'd0);
    check("rst_busy", 32'(REFILL_BUSY), 32'd0);
    check("rst_victim_valid", 32'(VICTIM_VALID), 32'd0);
    check("rst_refill_line", 32'(REFILL_LINE), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    tick();

    // Basic miss at 0x1040: tag 0, line 0x41, zero-wait L2.
    TAG_OUT_BANK_0_IF3 = 17'h00055;
    TAG_OUT_BANK_1_IF3 = 17'h00AAA;
    ADDRESS_TO_L2_READY_INS = 1'b1;
    PC_IF3 = 32'h0000_1040; PC_VALID_IF3 = 1'b1;
    exp_q.push_back(30'h0000_0410);
    #1;
    check("a_busy_miss_cycle", 32'(REFILL_BUSY), 32'd1);
    check("a_addr_valid_miss_cycle", 32'(ADDRESS_TO_L2_VALID_INS), 32'd0);
    tick();
    PC_VALID_IF3 = 1'b0;
    check("a_state_req", 32'(STATE_DBG), 32'd1);
    check("a_addr_valid", 32'(ADDRESS_TO_L2_VALID_INS), 32'd1);
    check("a_addr", 32'(ADDRESS_TO_L2_INS), 32'h0000_0410);
    tick();
    check("a_state_wait", 32'(STATE_DBG), 32'd2);
    check("a_addr_valid_drop", 32'(ADDRESS_TO_L2_VALID_INS), 32'd0);
    check("a_data_ready", 32'(DATA_FROM_L2_READY_INS), 32'd1);
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_a;
    tick();
    DATA_FROM_L2_VALID_INS = 1'b0; DATA_FROM_L2_INS = blk_junk;
    check("a_state_write", 32'(STATE_DBG), 32'd3);
    check("a_we", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'b01);
    check("a_line", 32'(REFILL_LINE), 32'h41);
    check("a_tag", 32'(REFILL_TAG), 32'h0);
    check_blk("a_block", REFILL_BLOCK, blk_a);
    check("a_victim_valid", 32'(VICTIM_VALID), 32'd1);
    check("a_victim_addr", 32'(VICTIM_TAG_ADDRESS), 32'({17'h00055, 9'h041}));
    tick();
    check("a_state_idle", 32'(STATE_DBG), 32'd0);
    check("a_we_done", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'd0);
    check("a_victim_done", 32'(VICTIM_VALID), 32'd0);
    check("a_busy_done", 32'(REFILL_BUSY), 32'd0);

    // L2 address back-pressure for 5 cycles; early L2 data must be dropped.
    ADDRESS_TO_L2_READY_INS = 1'b0;
    drive_miss(32'h0002_8080);
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_junk;
    for (int i = 0; i < 5; i++) begin
      check("b_stall_valid", 32'(ADDRESS_TO_L2_VALID_INS), 32'd1);
      check("b_stall_addr", 32'(ADDRESS_TO_L2_INS), 32'h0000_A020);
      check("b_stall_busy", 32'(REFILL_BUSY), 32'd1);
      tick();
    end
    ADDRESS_TO_L2_READY_INS = 1'b1;
    DATA_FROM_L2_VALID_INS = 1'b0;
    check("b_valid_6th", 32'(ADDRESS_TO_L2_VALID_INS), 32'd1);
    check("b_addr_6th", 32'(ADDRESS_TO_L2_INS), 32'h0000_A020);
    tick();
    check("b_state_wait", 32'(STATE_DBG), 32'd2);
    check_blk("b_early_data_dropped", REFILL_BLOCK, blk_a);
    tick();
    check("b_still_wait", 32'(STATE_DBG), 32'd2);
    check("b_busy_wait", 32'(REFILL_BUSY), 32'd1);
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_b;
    tick();
    DATA_FROM_L2_VALID_INS = 1'b0;
    check("b_we", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'b01);
    check("b_line", 32'(REFILL_LINE), 32'd2);
    check("b_tag", 32'(REFILL_TAG), 32'd5);
    check_blk("b_block", REFILL_BLOCK, blk_b);
    tick();

    // Hit bank 0 on line 1 (IF2 noise applied), then miss on line 1 -> bank 1.
    PC_IF2 = 32'hFFFF_FFFF; TAG_OUT_BANK_0_IF2 = 17'h1FFFF; TAG_OUT_BANK_1_IF2 = 17'h15555;
    PC_IF3 = 32'h0003_8040; PC_VALID_IF3 = 1'b1; HIT_BANK_0 = 1'b1;
    #1;
    check("c_busy_on_hit", 32'(REFILL_BUSY), 32'd0);
    tick();
    check("c_idle_after_hit", 32'(STATE_DBG), 32'd0);
    drive_miss(32'h0003_8040);
    check("c_state_req", 32'(STATE_DBG), 32'd1);
    tick();
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_c;
    tick();
    DATA_FROM_L2_VALID_INS = 1'b0;
    check("c_we_bank1", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'b10);
    check("c_victim_addr", 32'(VICTIM_TAG_ADDRESS), 32'({17'h00AAA, 9'd1}));
    tick();

    // Miss on line 1 again (LRU now 0) with a second miss held during the wait.
    req_snap = req_count;
    drive_miss(32'h0003_8040);
    PC_IF3 = 32'h0004_8180; PC_VALID_IF3 = 1'b1;
    tick();
    check("d_state_wait", 32'(STATE_DBG), 32'd2);
    tick();
    check("d_wait_ignores_miss", 32'(STATE_DBG), 32'd2);
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_a;
    tick();
    PC_VALID_IF3 = 1'b0;
    DATA_FROM_L2_VALID_INS = 1'b0;
    check("d_we_bank0", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'b01);
    check("d_line_captured", 32'(REFILL_LINE), 32'd1);
    check("d_tag_captured", 32'(REFILL_TAG), 32'd7);
    tick();
    tick();
    check("d_single_request", 32'(req_count - req_snap), 32'd1);
    check("d_idle", 32'(STATE_DBG), 32'd0);

    // Both banks hit on line 4: bank 0 wins, so the next miss evicts bank 1.
    PC_IF3 = 32'h0000_8100; PC_VALID_IF3 = 1'b1; HIT_BANK_0 = 1'b1; HIT_BANK_1 = 1'b1;
    tick();
    drive_miss(32'h0000_8100);
    tick();
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_b;
    tick();
    DATA_FROM_L2_VALID_INS = 1'b0;
    check("f_we_bank1", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'b10);
    check("f_victim_addr", 32'(VICTIM_TAG_ADDRESS), 32'({17'h00AAA, 9'd4}));
    tick();

    // Victim address on line 3 with bank 0 tag 0x1ABCD.
    TAG_OUT_BANK_0_IF3 = 17'h1ABCD;
    drive_miss(32'h0001_00C0);
    tick();
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_c;
    tick();
    DATA_FROM_L2_VALID_INS = 1'b0;
    check("e_victim_valid", 32'(VICTIM_VALID), 32'd1);
    check("e_victim_addr", 32'(VICTIM_TAG_ADDRESS), 32'h0357_9A03);
    check("e_we_bank0", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'b01);
    check("e_line", 32'(REFILL_LINE), 32'd3);
    check("e_tag", 32'(REFILL_TAG), 32'd2);
    tick();
    check("e_victim_pulse_end", 32'(VICTIM_VALID), 32'd0);

    // Reset while waiting for L2 data abandons the refill.
    drive_miss(32'h0001_8140);
    tick();
    check("g_state_wait", 32'(STATE_DBG), 32'd2);
    #2;
    RST_N = 1'b0;
    #1;
    check("g_rst_state", 32'(STATE_DBG), 32'd0);
    check("g_rst_ready", 32'(DATA_FROM_L2_READY_INS), 32'd0);
    check("g_rst_busy", 32'(REFILL_BUSY), 32'd0);
    check("g_rst_line", 32'(REFILL_LINE), 32'd0);
    check_blk("g_rst_block", REFILL_BLOCK, '0);
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_junk;
    tick();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("g_no_write", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'd0);
      check("g_no_victim", 32'(VICTIM_VALID), 32'd0);
      check("g_idle", 32'(STATE_DBG), 32'd0);
      tick();
    end
    DATA_FROM_L2_VALID_INS = 1'b0;

    // LRU was cleared by reset: line 0x41 (last filled in bank 0) evicts bank 0.
    drive_miss(32'h0000_1040);
    tick();
    DATA_FROM_L2_VALID_INS = 1'b1; DATA_FROM_L2_INS = blk_a;
    tick();
    DATA_FROM_L2_VALID_INS = 1'b0;
    check("h_we_bank0_after_reset", 32'({REFILL_WE_BANK_1, REFILL_WE_BANK_0}), 32'b01);
    tick();

    check("all_requests_seen", 32'(exp_q.size()), 32'd0);
    check("request_count", 32'(req_count), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
